// File: rtl/bank_arbiter.sv
// bank_arbiter
//   Round-robin arbiter that lets NREQ requesters share one single-ported
//   memory bank. One request is accepted per cycle and issued to the bank
//   one cycle later. Read responses come back two cycles after acceptance,
//   tagged (one-hot rsp_valid) to the requester that issued them.
//
// Parameters
//   NREQ    number of requesters
//   ADDR_W  address width
//   DATA_W  data width
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   req_valid[NREQ]     per-requester request strobe
//   req_we[NREQ]        per-requester write (1) / read (0)
//   req_addr            packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata           packed write data, same packing
//   req_ready[NREQ]     one-hot combinational grant
//   rsp_valid[NREQ]     one-hot read-response strobe
//   rsp_data            shared read data (valid when any rsp_valid bit set)
//   bank_addr           registered bank address
//   bank_data_in        registered bank write data
//   bank_read_enable    registered read command
//   bank_write_enable   registered write command (never with read)
//   bank_data_out       bank read data
//   bank_valid_out      bank read data valid (cycle after read_enable sampled)
//   conflict_cnt        saturating count of cycles with >=2 requests
//                       (present only when BANK_ARB_CONFLICT_CNT_EN is defined)
//
// Configuration macro: BANK_ARB_CONFLICT_CNT_EN

module bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [DATA_W-1:0]        bank_data_in,
  output logic                     bank_read_enable,
  output logic                     bank_write_enable,
  input  logic [DATA_W-1:0]        bank_data_out,
  input  logic                     bank_valid_out
`ifdef BANK_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic [NREQ-1:0]   gnt_oh;
  logic              gnt_any;
  logic [IDX_W-1:0]  cand_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  logic [IDX_W-1:0]  cmd_id;
  logic [IDX_W-1:0]  rsp_id;
  logic              rsp_pend;

  // Round-robin search starting just after the last winner.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!gnt_any && req_valid[cand_idx]) begin
        gnt_any          = 1'b1;
        gnt_idx          = cand_idx;
        gnt_oh[cand_idx] = 1'b1;
      end
    end
    if (reset) begin
      gnt_any = 1'b0;
      gnt_oh  = '0;
    end
  end

  assign req_ready = gnt_oh;

  // Select the winning requester's command fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
  end

  // ---- accept -> bank command stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant        <= IDX_W'(NREQ - 1);
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
      cmd_id            <= '0;
    end else if (gnt_any) begin
      last_grant        <= gnt_idx;
      bank_addr         <= sel_addr;
      bank_data_in      <= sel_wdata;
      bank_read_enable  <= !sel_we;
      bank_write_enable <= sel_we;
      cmd_id            <= gnt_idx;
    end else begin
      // Idle cycle: no command, address/data hold their last value.
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
    end
  end

  // ---- bank command -> response tag stage ----
  // bank_read_enable doubles as the valid of the command-stage tag, so only
  // reads arm rsp_pend and writes never produce a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id   <= '0;
      rsp_pend <= 1'b0;
    end else begin
      rsp_id   <= cmd_id;
      rsp_pend <= bank_read_enable;
    end
  end

  // Stray bank_valid_out without an outstanding read is ignored.
  always_comb begin
    rsp_valid = '0;
    if (rsp_pend && bank_valid_out)
      rsp_valid[rsp_id] = 1'b1;
  end

  assign rsp_data = bank_data_out;

`ifdef BANK_ARB_CONFLICT_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if ($countones(req_valid) >= 2)
      conflict_cnt <= sat_inc16(conflict_cnt);
  end
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
module tb_bank_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [ADDR_W-1:0]      bank_addr;
  logic [DATA_W-1:0]      bank_data_in;
  logic                   bank_read_enable;
  logic                   bank_write_enable;
  logic [DATA_W-1:0]      bank_data_out;
  logic                   bank_valid_out;
`ifdef BANK_ARB_CONFLICT_CNT_EN
  logic [15:0]            conflict_cnt;
`endif

  bank_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_addr(bank_addr), .bank_data_in(bank_data_in),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_data_out(bank_data_out), .bank_valid_out(bank_valid_out)
`ifdef BANK_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Simple bank: one-cycle read latency, writes land on the sampling edge.
  logic [7:0] mem [256];
  logic [7:0] bdout;
  logic       bv_reg;
  logic       force_bv;
  always @(posedge clk) begin
    if (bank_write_enable) mem[bank_addr] <= bank_data_in;
    if (bank_read_enable)  bdout <= mem[bank_addr];
    bv_reg <= bank_read_enable;
  end
  assign bank_valid_out = bv_reg | force_bv;
  assign bank_data_out  = bdout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  typedef struct { int id; logic [7:0] data; int due; } exp_t;
  exp_t       q[$];
  exp_t       e;
  logic [7:0] shadow [256];
  int         m_last;
  int         m_cnt;
  logic [7:0] exp_addr, exp_din;
  logic       exp_re, exp_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic set_reset(input logic r);
    reset = r;
    if (r) begin
      q.delete();
      m_last   = NREQ - 1;
      m_cnt    = 0;
      exp_addr = '0;
      exp_din  = '0;
      exp_re   = 1'b0;
      exp_we   = 1'b0;
    end
  endtask

  // Drive one cycle of requests, check the grant and the previous cycle's
  // bank command, update the model and queue any expected read response.
  task automatic step(input logic [3:0] v, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] d);
    int g;
    logic [7:0] ea, ed;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    chk("bank_read_enable",  32'(bank_read_enable),  32'(exp_re));
    chk("bank_write_enable", 32'(bank_write_enable), 32'(exp_we));
    chk("bank_addr",         32'(bank_addr),         32'(exp_addr));
    if (exp_we || reset) chk("bank_data_in", 32'(bank_data_in), 32'(exp_din));
    if (reset) chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
`ifdef BANK_ARB_CONFLICT_CNT_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    if (!reset && $countones(v) >= 2 && m_cnt < 65535) m_cnt++;
`endif
    g = -1;
    if (!reset)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (reset) begin
      // model already cleared by set_reset
    end else if (g >= 0) begin
      m_last   = g;
      ea       = 8'(a >> (8 * g));
      ed       = 8'(d >> (8 * g));
      exp_addr = ea;
      exp_din  = ed;
      exp_we   = we[g];
      exp_re   = !we[g];
      if (we[g]) shadow[ea] = ed;
      else       q.push_back('{g, shadow[ea], cyc + 2});
    end else begin
      exp_re = 1'b0;
      exp_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 32'd0, 32'd0);
  endtask

  function automatic logic [7:0] pick_addr();
    return ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
  endfunction

  // Response monitor: every rsp_valid must match the oldest queued read.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual rsp_valid=%b required=0000 (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
          chk("rsp_data",  32'(rsp_data),  32'(e.data));
          chk("rsp_cycle", 32'(cyc),       32'(e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL rsp_missing actual rsp_valid=0000 required=%0d (cycle %0d)", q[0].id, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'd0;
      shadow[i] = 8'd0;
    end
    bdout     = 8'd0;
    bv_reg    = 1'b0;
    force_bv  = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset with all requesters asserting: nothing may be granted.
    set_reset(1'b1);
    step(4'b1111, 4'b0000, 32'd0, 32'd0);
    step(4'b1111, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_reset(1'b0);
    idle(1);

    // req0 writes 24 to addr 9, then reads it back.
    step(4'b0001, 4'b0001, 32'd9, 32'd24);
    step(4'b0001, 4'b0000, 32'd9, 32'd0);
    idle(3);

    // req1 writes 145 to addr 255, req2 reads addr 255 next cycle.
    step(4'b0010, 4'b0010, 32'h0000FF00, 32'h00009100);
    step(4'b0100, 4'b0000, 32'h00FF0000, 32'd0);
    idle(3);

    // Pipelined reads from req0 and req3 on consecutive cycles.
    step(4'b0001, 4'b0000, 32'd9, 32'd0);
    step(4'b1000, 4'b0000, 32'hFF000000, 32'd0);
    idle(3);

    // All four requesters continuously for 8 cycles.
    for (int i = 0; i < 8; i++) step(4'b1111, 4'b0000, 32'hFF0009FF, 32'd0);
    idle(3);

    // Reset one cycle after a read accept drops the read.
    step(4'b0001, 4'b0000, 32'd9, 32'd0);
    set_reset(1'b1);
    step(4'b0000, 4'b0000, 32'd0, 32'd0);
    step(4'b1111, 4'b0000, 32'd0, 32'd0);
    set_reset(1'b0);
    idle(4);
    step(4'b1111, 4'b0000, 32'h09090909, 32'd0);
    idle(3);

    // Idle with a stuck bank_valid_out: no responses, pointer unchanged.
    force_bv = 1'b1;
    idle(5);
    force_bv = 1'b0;
    step(4'b1111, 4'b0000, 32'hFF09FF09, 32'd0);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      force_bv = ($urandom_range(0, 7) == 0);
      step(4'($urandom_range(0, 15)), 4'($urandom),
           {pick_addr(), pick_addr(), pick_addr(), pick_addr()}, $urandom);
    end
    force_bv = 1'b0;
    idle(4);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
